// File: rtl/core_pkg.sv
// Shared memOp codes, FSM state type and line geometry for the memory stage.
// Also holds the store-lane helpers used by both the cache write and the memory port.
package core_pkg;

  localparam logic [6:0] MOP_LDB  = 7'h10;
  localparam logic [6:0] MOP_LDW  = 7'h11;
  localparam logic [6:0] MOP_STB  = 7'h12;
  localparam logic [6:0] MOP_STW  = 7'h13;
  localparam logic [6:0] MOP_NONE = 7'h3F;

  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = 128;
  localparam int OFF_W      = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Little-endian pick of a byte (zero-extended) or an aligned word from a line.
  function automatic logic [31:0] extract(input logic [LINE_BITS-1:0] line,
                                          input logic [OFF_W-1:0]     off,
                                          input logic                 is_byte);
    logic [31:0] w;
    logic [7:0]  b;
    w = line[{off[3:2], 5'b00000} +: 32];
    b = line[{off, 3'b000} +: 8];
    return is_byte ? {24'h0, b} : w;
  endfunction

  function automatic logic [3:0] strb_of(input logic [6:0] op, input logic [1:0] lo);
    if (op == MOP_STB) return 4'b0001 << lo;
    if (op == MOP_STW) return 4'hF;
    return 4'h0;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [6:0] op, input logic [31:0] sd);
    if (op == MOP_STB) return {4{sd[7:0]}};
    if (op == MOP_STW) return sd;
    return 32'h0;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/tag/data per line, hit compare and
// byte-enabled line write. Only valid bits are reset; tags and data are qualified by them.
module dcache_array
  import core_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [27:0]           i_rd_line_addr,
  output logic                  o_hit,
  output logic [LINE_BITS-1:0]  o_rd_data,
  input  logic                  i_wr_en,
  input  logic                  i_wr_fill,
  input  logic [27:0]           i_wr_line_addr,
  input  logic [LINE_BYTES-1:0] i_wr_be,
  input  logic [LINE_BITS-1:0]  i_wr_data
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  logic [LINES-1:0]     r_valid;
  logic [TW-1:0]        r_tag  [LINES];
  logic [LINE_BITS-1:0] r_data [LINES];
  logic [IW-1:0]        w_rd_idx;
  logic [IW-1:0]        w_wr_idx;

  assign w_rd_idx  = i_rd_line_addr[IW-1:0];
  assign w_wr_idx  = i_wr_line_addr[IW-1:0];
  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == i_rd_line_addr[27:IW]);
  assign o_rd_data = r_data[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_wr_en && i_wr_fill) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      if (i_wr_fill) r_tag[w_wr_idx] <= i_wr_line_addr[27:IW];
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (i_wr_be[b]) r_data[w_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: write-through direct-mapped D-cache with a blocking
// miss/store FSM. Optional hit/miss/store counters are built when MEM_STAGE_STATS_EN is defined.
//   state   | meaning
//   ST_IDLE | accepting ops; hits and pass-through retire in one cycle
//   ST_BUSY | line read or word write outstanding, waiting for mem_ack
module mem_stage
  import core_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [6:0]   memop_in,
  input  logic [31:0]  addr_in,
  input  logic [4:0]   dst_in,
  input  logic [31:0]  store_data_in,
  output logic         stall,
  output logic         wb_we,
  output logic [4:0]   wb_reg,
  output logic [31:0]  wb_data,
  output logic [4:0]   bp_reg_mem,
  output logic [31:0]  bp_data_mem,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wstrb,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ack
`ifdef MEM_STAGE_STATS_EN
  ,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses,
  output logic [31:0]  stat_stores
`endif
);

  state_t r_state, w_state_nxt;
  logic [6:0]  r_op;
  logic [31:0] r_addr;
  logic [4:0]  r_dst;
  logic [31:0] r_sdata;

  logic         w_is_load, w_is_store, w_is_none, w_hit, w_go_busy;
  logic         w_r_is_store, w_fill, w_st_hit;
  logic [127:0] w_rd_line;
  logic [15:0]  w_st_be;
  logic [31:0]  w_st_wdata;

  assign w_is_load    = (memop_in == MOP_LDB) || (memop_in == MOP_LDW);
  assign w_is_store   = (memop_in == MOP_STB) || (memop_in == MOP_STW);
  assign w_is_none    = (memop_in == MOP_NONE);
  assign w_go_busy    = (w_is_load && !w_hit) || w_is_store;
  assign w_r_is_store = (r_op == MOP_STB) || (r_op == MOP_STW);
  assign w_fill       = (r_state == ST_BUSY) && mem_ack && !w_r_is_store;
  assign w_st_hit     = (r_state == ST_IDLE) && w_is_store && w_hit;
  assign w_st_wdata   = wdata_of(memop_in, store_data_in);
  assign w_st_be      = 16'(strb_of(memop_in, addr_in[1:0])) << {addr_in[3:2], 2'b00};

  dcache_array #(.LINES(LINES)) u_dcache (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rd_line_addr (addr_in[31:4]),
    .o_hit          (w_hit),
    .o_rd_data      (w_rd_line),
    .i_wr_en        (w_fill || w_st_hit),
    .i_wr_fill      (w_fill),
    .i_wr_line_addr (w_fill ? r_addr[31:4] : addr_in[31:4]),
    .i_wr_be        (w_fill ? 16'hFFFF : w_st_be),
    .i_wr_data      (w_fill ? mem_rdata : {4{w_st_wdata}})
  );

  // Port fields come from the latched op so they stay frozen for the whole BUSY period.
  assign mem_we      = w_r_is_store;
  assign mem_addr    = w_r_is_store ? {r_addr[31:2], 2'b00} : {r_addr[31:4], 4'h0};
  assign mem_wdata   = wdata_of(r_op, r_sdata);
  assign mem_wstrb   = strb_of(r_op, r_addr[1:0]);
  assign bp_reg_mem  = wb_we ? wb_reg  : 5'd0;
  assign bp_data_mem = wb_we ? wb_data : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go_busy) begin
          stall       = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = !mem_ack;
        if (mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_dst   <= '0;
      r_sdata <= '0;
      mem_req <= 1'b0;
      wb_we   <= 1'b0;
      wb_reg  <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_go_busy) begin
          r_op    <= memop_in;
          r_addr  <= addr_in;
          r_dst   <= dst_in;
          r_sdata <= store_data_in;
          mem_req <= 1'b1;
        end else if (w_is_load) begin
          wb_we   <= 1'b1;
          wb_reg  <= dst_in;
          wb_data <= extract(w_rd_line, addr_in[3:0], memop_in == MOP_LDB);
        end else if (!w_is_none) begin
          wb_we   <= 1'b1;
          wb_reg  <= dst_in;
          wb_data <= addr_in;
        end
      end else if (mem_ack) begin
        mem_req <= 1'b0;
        if (!w_r_is_store) begin
          wb_we   <= 1'b1;
          wb_reg  <= r_dst;
          wb_data <= extract(mem_rdata, r_addr[3:0], r_op == MOP_LDB);
        end
      end
    end
  end

`ifdef MEM_STAGE_STATS_EN
  logic [31:0] r_hits, r_misses, r_stores;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hits   <= '0;
      r_misses <= '0;
      r_stores <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_is_load && w_hit) r_hits <= r_hits + 32'd1;
      if (w_fill) r_misses <= r_misses + 32'd1;
      if ((r_state == ST_BUSY) && mem_ack && w_r_is_store) r_stores <= r_stores + 32'd1;
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
  assign stat_stores = r_stores;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-level memory model plus a line-presence model
// predict writebacks and memory requests; a responder and a monitor check them.
module tb_mem_stage;

  localparam int LINES = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [6:0]   memop_in;
  logic [31:0]  addr_in;
  logic [4:0]   dst_in;
  logic [31:0]  store_data_in;
  logic         stall, wb_we, mem_req, mem_we, mem_ack;
  logic [4:0]   wb_reg, bp_reg_mem;
  logic [31:0]  wb_data, bp_data_mem, mem_addr, mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [127:0] mem_rdata;
`ifdef MEM_STAGE_STATS_EN
  logic [31:0]  stat_hits, stat_misses, stat_stores;
`endif

  mem_stage #(.LINES(LINES)) dut (
    .clk(clk), .rst_n(rst_n), .memop_in(memop_in), .addr_in(addr_in), .dst_in(dst_in),
    .store_data_in(store_data_in), .stall(stall), .wb_we(wb_we), .wb_reg(wb_reg),
    .wb_data(wb_data), .bp_reg_mem(bp_reg_mem), .bp_data_mem(bp_data_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef MEM_STAGE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_stores(stat_stores)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] r; logic [31:0] d; } wb_t;
  typedef struct { logic we; logic [31:0] a; logic [31:0] wd; logic [3:0] st; } req_t;

  int n_chk = 0;
  int n_fail = 0;
  wb_t  exp_wb[$];
  req_t exp_req[$];
  logic [7:0]  mem_b [int unsigned];
  bit          vld [LINES];
  logic [27:0] vline [LINES];
  bit          resp_en = 1'b1;
  int          fixed_lat = -1;
  logic [6:0]  ops [9] = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h3F, 7'h00, 7'h05, 7'h14, 7'h7F};

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_b(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return 8'(a * 32'd7 + (a >> 5) + 32'h3C);
  endfunction

  function automatic logic [31:0] rd_w(input logic [31:0] a);
    return {rd_b(a + 3), rd_b(a + 2), rd_b(a + 1), rd_b(a)};
  endfunction

  // Upstream model: present an op, predict its effects, hold it while stall is high.
  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [4:0] d,
                       input logic [31:0] sd, output int sc);
    int idx;
    logic [27:0] ln;
    bit exp_stall;
    wb_t w;
    req_t r;
    ln = a[31:4];
    idx = int'(a[31:4]) % LINES;
    exp_stall = 1'b0;
    @(posedge clk); #1;
    memop_in = op; addr_in = a; dst_in = d; store_data_in = sd;
    case (op)
      7'h3F: ;
      7'h10, 7'h11: begin
        if (!(vld[idx] && vline[idx] == ln)) begin
          exp_stall = 1'b1;
          r.we = 1'b0; r.a = {a[31:4], 4'h0}; r.wd = '0; r.st = '0;
          exp_req.push_back(r);
          vld[idx] = 1'b1;
          vline[idx] = ln;
        end
        w.r = d;
        w.d = (op == 7'h10) ? {24'h0, rd_b(a)} : rd_w({a[31:2], 2'b00});
        exp_wb.push_back(w);
      end
      7'h12: begin
        exp_stall = 1'b1;
        r.we = 1'b1; r.a = {a[31:2], 2'b00}; r.wd = {4{sd[7:0]}}; r.st = 4'b0001 << a[1:0];
        exp_req.push_back(r);
        mem_b[a] = sd[7:0];
      end
      7'h13: begin
        exp_stall = 1'b1;
        r.we = 1'b1; r.a = {a[31:2], 2'b00}; r.wd = sd; r.st = 4'hF;
        exp_req.push_back(r);
        for (int k = 0; k < 4; k++) mem_b[{a[31:2], 2'b00} + k] = sd[k*8 +: 8];
      end
      default: begin
        w.r = d; w.d = a;
        exp_wb.push_back(w);
      end
    endcase
    sc = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (!stall) break;
      sc++;
    end
    check("issue_within_budget", sc < 60, 1'b1);
    check("stall_predicted", sc > 0, exp_stall);
  endtask

  // Memory responder: checks each request against the prediction, then acks after a latency.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && mem_req) begin
        req_t e;
        logic [69:0] snap;
        logic [31:0] a;
        int lat;
        a = mem_addr;
        if (exp_req.size() == 0) begin
          check("unexpected_mem_req", 1'b1, 1'b0);
        end else begin
          e = exp_req.pop_front();
          check("req_we", mem_we, e.we);
          check("req_addr", mem_addr, e.a);
          if (e.we) begin
            check("req_wdata", mem_wdata, e.wd);
            check("req_wstrb", mem_wstrb, e.st);
          end
        end
        snap = {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb};
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        repeat (lat) begin
          @(negedge clk);
          check("req_held_stable", {mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb}, snap);
        end
        for (int b = 0; b < 16; b++) mem_rdata[b*8 +: 8] = rd_b(a + b);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
  end

  // Writeback monitor and bypass consistency.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("bp_reg_mem", bp_reg_mem, wb_we ? wb_reg : 5'd0);
        check("bp_data_mem", bp_data_mem, wb_we ? wb_data : 32'd0);
        if (wb_we) begin
          if (exp_wb.size() == 0) begin
            check("unexpected_wb", 1'b1, 1'b0);
          end else begin
            wb_t e;
            e = exp_wb.pop_front();
            check("wb_reg", wb_reg, e.r);
            check("wb_data", wb_data, e.d);
          end
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    rst_n = 1'b0;
    memop_in = 7'h3F; addr_in = '0; dst_in = '0; store_data_in = '0;
    mem_b[32'h44] = 8'hEF; mem_b[32'h45] = 8'hBE; mem_b[32'h46] = 8'hAD; mem_b[32'h47] = 8'hDE;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_reg", wb_reg, 5'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_bp_reg", bp_reg_mem, 5'd0);
    check("rst_bp_data", bp_data_mem, 32'd0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", mem_wstrb, 4'd0);
    check("rst_stall", stall, 1'b0);
    rst_n = 1'b1;

    fixed_lat = 3;
    issue(7'h11, 32'h44, 5'd7, 32'd0, sc);
    check("ldw_miss_stall_cycles", sc, 4);
    fixed_lat = -1;
    issue(7'h11, 32'h44, 5'd8, 32'd0, sc);
    check("ldw_hit_stall_cycles", sc, 0);
    issue(7'h10, 32'h45, 5'd9, 32'd0, sc);
    fixed_lat = 0;
    issue(7'h12, 32'h46, 5'd0, 32'h77, sc);
    check("store_min_stall_cycles", sc, 1);
    fixed_lat = -1;
    issue(7'h11, 32'h44, 5'd10, 32'd0, sc);
    issue(7'h13, 32'h100, 5'd0, 32'hCAFEF00D, sc);
    issue(7'h11, 32'h100, 5'd11, 32'd0, sc);

    issue(7'h00, 32'd5, 5'd3, 32'd0, sc);
    @(posedge clk); #1;
    memop_in = 7'h3F;
    check("add_wb_we", wb_we, 1'b1);
    check("add_bp_reg", bp_reg_mem, 5'd3);
    check("add_bp_data", bp_data_mem, 32'd5);
    @(posedge clk); #1;
    check("bubble_wb_we", wb_we, 1'b0);
    check("bubble_bp_reg", bp_reg_mem, 5'd0);
    check("bubble_bp_data", bp_data_mem, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      logic [31:0] a;
      op = ops[$urandom_range(0, 8)];
      a = (op inside {[7'h10:7'h13]}) ? 32'($urandom_range(0, 1023)) : $urandom;
      issue(op, a, 5'($urandom), $urandom, sc);
    end

    // Reset in the middle of an outstanding line read.
    resp_en = 1'b0;
    @(posedge clk); #1;
    memop_in = 7'h11; addr_in = 32'h1000; dst_in = 5'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check("rwb_req_up", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rwb_req_drop", mem_req, 1'b0);
    check("rwb_wb_we", wb_we, 1'b0);
    memop_in = 7'h3F;
    for (int k = 0; k < LINES; k++) vld[k] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_en = 1'b1;
    issue(7'h11, 32'h44, 5'd12, 32'd0, sc);

    @(posedge clk); #1;
    memop_in = 7'h3F;
    repeat (4) @(negedge clk);
    check("wb_queue_drained", exp_wb.size(), 0);
    check("req_queue_drained", exp_req.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
